seq_detect_ctrl: RTL and testbench

//  Sequencer for a serial bit-stream sequence detector (1-bit x in, registered z out).

---
 rtl/seq_detect_ctrl.sv | 132 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serializes a parallel word into a bit-serial sequence
// detector and collects the per-bit match map and match count.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start, abort  begin a run (IDLE only) / cancel an active run
//   msb_first     serialize order, sampled with start
//   din           word to serialize, sampled with start
//   det_x, det_en bit and valid strobe driven to the detector
//   det_z         detector output, attributed back to its bit
//   busy, done    run in progress / one-cycle completion pulse
//   match_cnt     number of bits whose z was 1
//   match_map     per-bit z map, bit 0 = first serialized bit
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int Z_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] din,
    output logic             det_x,
    output logic             det_en,
    input  logic             det_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic [WIDTH-1:0] match_map
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    // cyc counts cycles since the start edge; it must reach WIDTH+Z_LAT.
    localparam int CW = $clog2(WIDTH + Z_LAT + 2);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic             msb;
    logic [CW-1:0]    cyc;

    // z seen in cycle c belongs to bit c-Z_LAT-1; earlier z is ignored.
    logic          attr;
    logic [IW-1:0] bidx;

    assign attr = (cyc >= CW'(Z_LAT + 1));
    assign bidx = IW'(cyc - CW'(Z_LAT + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            msb       <= 1'b0;
            cyc       <= '0;
            det_x     <= 1'b0;
            det_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match_cnt <= '0;
            match_map <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SHIFT;
                        busy      <= 1'b1;
                        det_en    <= 1'b1;
                        msb       <= msb_first;
                        det_x     <= msb_first ? din[WIDTH-1] : din[0];
                        sreg      <= msb_first ? (din << 1) : (din >> 1);
                        cyc       <= CW'(1);
                        match_cnt <= '0;
                        match_map <= '0;
                    end
                end

                SHIFT, DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        det_en    <= 1'b0;
                        det_x     <= 1'b0;
                        sreg      <= '0;
                        cyc       <= '0;
                        match_cnt <= '0;
                        match_map <= '0;
                    end else begin
                        cyc <= cyc + CW'(1);
                        if (attr && det_z) begin
                            match_map[bidx] <= 1'b1;
                            match_cnt       <= match_cnt + CNT_W'(1);
                        end
                        if (state == SHIFT) begin
                            if (cyc == CW'(WIDTH)) begin
                                state  <= DRAIN;
                                det_en <= 1'b0;
                                det_x  <= 1'b0;
                            end else begin
                                det_x <= msb ? sreg[WIDTH-1] : sreg[0];
                                sreg  <= msb ? (sreg << 1) : (sreg >> 1);
                            end
                        end else if (cyc == CW'(WIDTH + Z_LAT)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cyc   <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed stimulus with a done-driven scoreboard
// around seq_detect_ctrl and an echo detector (det_z <= det_x).
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       msb_first = 1'b0;
    logic [7:0] din = 8'h00;
    logic       det_x;
    logic       det_en;
    logic       det_z = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] match_cnt;
    logic [7:0] match_map;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dones = 0;

    typedef struct {
        logic [3:0] cnt;
        logic [7:0] map;
        int         dcyc;
    } exp_t;

    exp_t sb[$];

    seq_detect_ctrl #(
        .WIDTH(8),
        .CNT_W(4),
        .Z_LAT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .msb_first(msb_first),
        .din      (din),
        .det_x    (det_x),
        .det_en   (det_en),
        .det_z    (det_z),
        .busy     (busy),
        .done     (done),
        .match_cnt(match_cnt),
        .match_map(match_map)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        det_z <= det_x;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 want 0 (cycle %0d)",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.dcyc);
                chk("match_cnt", 32'(match_cnt), 32'(e.cnt));
                chk("match_map", 32'(match_map), 32'(e.map));
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    // Called just after a negedge; returns at the negedge of cycle 1.
    task automatic start_run(input logic [7:0] d, input logic m,
                             input bit push, input logic [3:0] c,
                             input logic [7:0] mp);
        exp_t e;
        start     = 1'b1;
        din       = d;
        msb_first = m;
        if (push) begin
            e.cnt  = c;
            e.map  = mp;
            e.dcyc = cyc + 10;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_det_en"}, 32'(det_en), 32'd0);
        chk({tag, "_det_x"}, 32'(det_x), 32'd0);
        chk({tag, "_cnt"}, 32'(match_cnt), 32'd0);
        chk({tag, "_map"}, 32'(match_map), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int         d0;
        int         c0;
        exp_t       e;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: msb-first serialization and bit attribution
        b = 8'b1011_0010;
        start_run(b, 1'b1, 1'b1, 4'd4, 8'b0100_1101);
        for (int k = 0; k < 8; k++) begin
            chk("t1_det_en", 32'(det_en), 32'd1);
            chk("t1_det_x", 32'(det_x), 32'(b[7-k]));
            @(negedge clk);
        end
        chk("t1_drain_en", 32'(det_en), 32'd0);
        chk("t1_drain_x", 32'(det_x), 32'd0);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        wait_drain();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: lsb-first
        start_run(8'h01, 1'b0, 1'b1, 4'd1, 8'h01);
        chk("t2_first_x", 32'(det_x), 32'd1);
        @(negedge clk);
        chk("t2_second_x", 32'(det_x), 32'd0);
        wait_drain();

        // 3: start while busy is ignored
        start_run(8'hFF, 1'b1, 1'b1, 4'd8, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        din   = 8'h00;
        @(negedge clk);
        start = 1'b0;
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_det_x", 32'(det_x), 32'd1);
        wait_drain();

        // 4: abort in SHIFT
        d0 = dones;
        start_run(8'hAA, 1'b1, 1'b0, 4'd0, 8'h00);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_zero("t4_abort");
        repeat (12) @(negedge clk);
        chk("t4_no_done", d0, dones);

        // 5: reset mid-run, then a fresh run
        start_run(8'h3C, 1'b1, 1'b0, 4'd0, 8'h00);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("t5_rst");
        @(negedge clk);
        start_run(8'h0F, 1'b1, 1'b1, 4'd4, 8'hF0);
        wait_drain();

        // 6: start held high gives back-to-back runs with one IDLE gap
        c0        = cyc;
        start     = 1'b1;
        din       = 8'h81;
        msb_first = 1'b1;
        for (int r = 0; r < 3; r++) begin
            e.cnt  = 4'd2;
            e.map  = 8'h81;
            e.dcyc = c0 + 10 + 11 * r;
            sb.push_back(e);
        end
        repeat (23) @(negedge clk);
        start = 1'b0;
        wait_drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
